alu_op_sequencer: RTL and testbench

Initiator-side companion to the 4-bit registered ALU. It accepts operand/opcode commands from an upstream valid/ready source and buffers them. It drives them onto the ALU's `a`/`b`/`op` inputs at up to one per cycle, then captures each registered `result` at the correct cycle. It returns each result with an internally computed expected value and a mismatch flag, using a downstream valid/ready handshake. It sits between a command source (CPU-side register bank or test sequencer) and the ALU instance.

---
 rtl/alu_op_sequencer_if.sv | 48 ++++
 rtl/alu_op_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response bundle between a command source, the
// sequencer and the registered 4-bit ALU.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_result;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_a;
  logic [3:0] rsp_b;
  logic [1:0] rsp_op;
  logic [3:0] rsp_result;
  logic [3:0] rsp_expected;
  logic       rsp_mismatch;

  logic [7:0] err_count;
  logic       busy;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result,
    output rsp_valid, rsp_a, rsp_b, rsp_op, rsp_result, rsp_expected, rsp_mismatch,
    input  rsp_ready,
    output err_count, busy
  );

  // Command source / response sink / ALU side
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result,
    input  rsp_valid, rsp_a, rsp_b, rsp_op, rsp_result, rsp_expected, rsp_mismatch,
    output rsp_ready,
    input  err_count, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands, drives them onto a registered ALU one per cycle,
// captures each result two cycles after issue and returns it alongside a
// locally modelled expected value.
module alu_op_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = AW + 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  typedef struct packed {
    cmd_t       cmd;
    logic [3:0] result;
    logic [3:0] expected;
  } rsp_t;

  // Reference behaviour of the ALU; carry and borrow are dropped.
  function automatic logic [3:0] alu_model(input cmd_t c);
    logic [3:0] r;
    case (c.op)
      OP_ADD:  r = c.a + c.b;
      OP_SUB:  r = c.a - c.b;
      OP_AND:  r = c.a & c.b;
      OP_OR:   r = c.a | c.b;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  cmd_t          cmd_mem [DEPTH];
  logic [PW-1:0] cmd_wptr;
  logic [PW-1:0] cmd_rptr;
  logic          cmd_empty;
  logic          cmd_full;
  logic          cmd_push;
  cmd_t          cmd_in;
  cmd_t          cmd_head;

  // ---------------------------------------------------------------------
  // Issue / wait pipeline
  // ---------------------------------------------------------------------
  cmd_t          alu_q;      // stage-1 command, also the ALU drive
  logic          v1;
  cmd_t          s2;         // stage-2 shadow, aligned with alu_result
  logic          v2;
  logic          issue;
  logic [CW-1:0] credit_used;

  // ---------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------
  rsp_t          rsp_mem [DEPTH];
  logic [PW-1:0] rsp_wptr;
  logic [PW-1:0] rsp_rptr;
  logic [PW-1:0] rsp_count;
  logic          rsp_empty;
  logic          rsp_pop;
  rsp_t          rsp_in;
  rsp_t          rsp_head;
  logic          capture_mismatch;

  logic [7:0]    err_q;

  // Command FIFO status and handshake
  always_comb begin
    cmd_empty = (cmd_wptr == cmd_rptr);
    cmd_full  = (cmd_wptr[AW] != cmd_rptr[AW]) &&
                (cmd_wptr[AW-1:0] == cmd_rptr[AW-1:0]);
    cmd_push  = bus.cmd_valid && !cmd_full;
    cmd_in    = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
    cmd_head  = cmd_mem[cmd_rptr[AW-1:0]];
  end

  // Issue only when every in-flight result is guaranteed a response slot
  always_comb begin
    rsp_count   = rsp_wptr - rsp_rptr;
    credit_used = CW'(rsp_count) + CW'(v1) + CW'(v2);
    issue       = !cmd_empty && (credit_used < CW'(DEPTH));
  end

  // Capture payload for the result the ALU is presenting this cycle
  always_comb begin
    rsp_in           = '{cmd: s2, result: bus.alu_result, expected: alu_model(s2)};
    capture_mismatch = v2 && (bus.alu_result != rsp_in.expected);
    rsp_empty        = (rsp_wptr == rsp_rptr);
    rsp_pop          = !rsp_empty && bus.rsp_ready;
    rsp_head         = rsp_empty ? '0 : rsp_mem[rsp_rptr[AW-1:0]];
  end

  // Command storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wptr[AW-1:0]] <= cmd_in;
    end
  end

  // Command FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wptr <= '0;
      cmd_rptr <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + PW'(1);
      if (issue)    cmd_rptr <= cmd_rptr + PW'(1);
    end
  end

  // Issue and wait stages; idle cycles drive zeros to the ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q <= '0;
      v1    <= 1'b0;
      s2    <= '0;
      v2    <= 1'b0;
    end else begin
      alu_q <= issue ? cmd_head : '0;
      v1    <= issue;
      s2    <= alu_q;
      v2    <= v1;
    end
  end

  // Response storage; credit rule keeps a push from ever seeing full
  always_ff @(posedge clk) begin
    if (v2) begin
      rsp_mem[rsp_wptr[AW-1:0]] <= rsp_in;
    end
  end

  // Response FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wptr <= '0;
      rsp_rptr <= '0;
    end else begin
      if (v2)      rsp_wptr <= rsp_wptr + PW'(1);
      if (rsp_pop) rsp_rptr <= rsp_rptr + PW'(1);
    end
  end

  // Saturating mismatch counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (capture_mismatch && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.cmd_ready    = !cmd_full;
  assign bus.alu_a        = alu_q.a;
  assign bus.alu_b        = alu_q.b;
  assign bus.alu_op       = alu_q.op;
  assign bus.rsp_valid    = !rsp_empty;
  assign bus.rsp_a        = rsp_head.cmd.a;
  assign bus.rsp_b        = rsp_head.cmd.b;
  assign bus.rsp_op       = rsp_head.cmd.op;
  assign bus.rsp_result   = rsp_head.result;
  assign bus.rsp_expected = rsp_head.expected;
  assign bus.rsp_mismatch = !rsp_empty && (rsp_head.result != rsp_head.expected);
  assign bus.err_count    = err_q;
  assign bus.busy         = !cmd_empty || v1 || v2 || !rsp_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a registered ALU model that can
// be switched to return a+b+1 on add.
module tb_alu_op_sequencer;

  logic clk;
  logic rst;
  logic alu_bad;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic [3:0] exp;
    logic       mis;
  } exp_t;

  exp_t sb [$];
  int   pop_cyc [$];
  int   checks = 0;
  int   errors = 0;
  int   unexpected = 0;
  int   cyc = 0;
  int   acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter for latency/throughput checks
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU under test
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_result <= 4'd0;
    end else begin
      case (bus.alu_op)
        2'b00:   bus.alu_result <= bus.alu_a + bus.alu_b + (alu_bad ? 4'd1 : 4'd0);
        2'b01:   bus.alu_result <= bus.alu_a - bus.alu_b;
        2'b10:   bus.alu_result <= bus.alu_a & bus.alu_b;
        default: bus.alu_result <= bus.alu_a | bus.alu_b;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Response monitor: compares every response handed downstream
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        unexpected++;
        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("rsp", 32'({bus.rsp_a, bus.rsp_b, bus.rsp_op, bus.rsp_result,
                        bus.rsp_expected, bus.rsp_mismatch}),
                   32'({e.a, e.b, e.op, e.res, e.exp, e.mis}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command, hold until accepted, record its expectation
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input logic [3:0] res, input logic [3:0] exp);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        sb.push_back('{a: a, b: b, op: op, res: res, exp: exp, mis: (res != exp)});
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("cmd_accept_timeout", 32'(ok), 32'(1));
    tick();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600 && sb.size() != 0; i++) tick();
    chk(name, 32'(sb.size()), 32'(0));
  endtask

  // Called right after a lone command was accepted at edge E
  task automatic check_latency(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bus.cmd_valid = 1'b0;
    chk("lat_e0_valid", 32'(bus.rsp_valid), 32'(0));
    tick();
    chk("lat_e1_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'({a, b, op}));
    chk("lat_e1_valid", 32'(bus.rsp_valid), 32'(0));
    tick();
    chk("lat_e2_alu_idle", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'(0));
    chk("lat_e2_valid", 32'(bus.rsp_valid), 32'(0));
    tick();
    chk("lat_e3_valid", 32'(bus.rsp_valid), 32'(1));
  endtask

  // Stall-test stream step: one cycle of held cmd_valid with add k+1
  task automatic stream_step();
    @(negedge clk);
    if (bus.cmd_valid && bus.cmd_ready) begin
      sb.push_back('{a: bus.cmd_a, b: 4'd1, op: 2'b00, res: bus.cmd_a + 4'd1,
                     exp: bus.cmd_a + 4'd1, mis: 1'b0});
      acc++;
    end
    tick();
    if (acc >= 10) bus.cmd_valid = 1'b0;
    else           bus.cmd_a = 4'(acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'(1));
    chk({tag, "_alu"}, 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    chk({tag, "_rsp_fields"}, 32'({bus.rsp_a, bus.rsp_b, bus.rsp_op, bus.rsp_result,
                                   bus.rsp_expected, bus.rsp_mismatch}), 32'(0));
    chk({tag, "_err_count"}, 32'(bus.err_count), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
  endtask

  initial begin
    alu_bad = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 4'd0;
    bus.cmd_b = 4'd0;
    bus.cmd_op = 2'b00;
    bus.rsp_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single add 7+9 wraps to 0, three-cycle latency
    send(4'd7, 4'd9, 2'b00, 4'd0, 4'd0);
    check_latency(4'd7, 4'd9, 2'b00);
    wait_drain("drain_single");

    // Back-to-back sub/and/or, responses on consecutive cycles
    pop_cyc.delete();
    send(4'd3, 4'd5, 2'b01, 4'd14, 4'd14);
    send(4'hC, 4'hA, 2'b10, 4'd8, 4'd8);
    send(4'h5, 4'h2, 2'b11, 4'd7, 4'd7);
    bus.cmd_valid = 1'b0;
    wait_drain("drain_b2b");
    tick();
    chk("b2b_count", 32'(pop_cyc.size()), 32'(3));
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'(1));
      chk("b2b_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'(1));
    end

    // Stall: exactly 2*DEPTH accepted, then release and finish the stream
    bus.rsp_ready = 1'b0;
    acc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 4'd0;
    bus.cmd_b = 4'd1;
    bus.cmd_op = 2'b00;
    for (int c = 0; c < 20; c++) stream_step();
    chk("stall_accepted", 32'(acc), 32'(8));
    chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'(1));
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && acc < 10; c++) stream_step();
    bus.cmd_valid = 1'b0;
    chk("resume_accepted", 32'(acc), 32'(10));
    wait_drain("drain_stall");

    // Faulty ALU on add: mismatch flagged, counter counts then saturates
    alu_bad = 1'b1;
    for (int i = 0; i < 4; i++) send(4'(i), 4'd2, 2'b00, 4'(i + 3), 4'(i + 2));
    bus.cmd_valid = 1'b0;
    wait_drain("drain_bad4");
    tick();
    chk("err_count_4", 32'(bus.err_count), 32'(4));
    for (int i = 0; i < 296; i++) send(4'(i), 4'(i >> 4), 2'b00, 4'(i + (i >> 4) + 1), 4'(i + (i >> 4)));
    bus.cmd_valid = 1'b0;
    wait_drain("drain_bad300");
    tick();
    chk("err_count_sat", 32'(bus.err_count), 32'(255));
    alu_bad = 1'b0;

    // Mid-operation reset: two in flight, three queued
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'(i), 4'd3, 2'b00, 4'(i + 3), 4'(i + 3));
    bus.cmd_valid = 1'b0;
    repeat (6) tick();
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    bus.rsp_ready = 1'b0;
    send(4'd9, 4'd9, 2'b00, 4'd2, 4'd2);
    bus.cmd_valid = 1'b0;
    chk("pre_reset_busy", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    unexpected = 0;
    repeat (8) tick();
    chk("no_stale_rsp", 32'(unexpected), 32'(0));
    chk("post_reset_valid", 32'(bus.rsp_valid), 32'(0));
    send(4'd6, 4'd2, 2'b01, 4'd4, 4'd4);
    check_latency(4'd6, 4'd2, 2'b01);
    wait_drain("drain_post_reset");

    // Response FIFO push and pop in the same cycle at occupancy 1
    bus.rsp_ready = 1'b0;
    send(4'd1, 4'd2, 2'b00, 4'd3, 4'd3);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) tick();
    chk("occ1_valid", 32'(bus.rsp_valid), 32'(1));
    send(4'd4, 4'hE, 2'b10, 4'd4, 4'd4);
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("occ1_after_valid", 32'(bus.rsp_valid), 32'(1));
    chk("occ1_after_head", 32'({bus.rsp_a, bus.rsp_b, bus.rsp_op}), 32'({4'd4, 4'hE, 2'b10}));
    tick();
    chk("occ1_hold_valid", 32'(bus.rsp_valid), 32'(1));
    bus.rsp_ready = 1'b1;
    wait_drain("drain_occ1");
    tick();
    chk("occ1_empty", 32'(bus.rsp_valid), 32'(0));
    chk("final_busy", 32'(bus.busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
